// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesting clients/transmitter side and the shared UART
// transmit arbiter.
//
// Handshake semantics (req/grant, tx_start/tx_done_tick):
//   A client raises req[i] with its character on req_data[i*DBIT +: DBIT] and
//   holds both stable until it sees grant[i] high for one cycle; grant[i] is
//   the only acceptance indication. tx_start is a 1-cycle launch pulse that
//   coincides with the grant, and tx_din is held until the next grant.
//   tx_done_tick is a 1-cycle pulse from the transmitter marking the end of a
//   character; it is only honoured while a character is in flight and
//   tx_start is low.
//
// The slave modport is the arbiter; the master modport is the client and
// transmitter side. state exposes the arbiter FSM for observation.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      grant;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_din;
    logic                 tx_done_tick;
    logic                 busy;
    logic [IDW-1:0]       cur_id;
    logic                 timeout_tick;
    logic [1:0]           state;

    modport master (
        output req,
        output req_data,
        output tx_done_tick,
        input  grant,
        input  tx_start,
        input  tx_din,
        input  busy,
        input  cur_id,
        input  timeout_tick,
        input  state
    );

    modport slave (
        input  req,
        input  req_data,
        input  tx_done_tick,
        output grant,
        output tx_start,
        output tx_din,
        output busy,
        output cur_id,
        output timeout_tick,
        output state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ requesters.
// One character per grant: the winner's character is launched with a 1-cycle
// tx_start, the arbiter then waits for the transmitter's done tick and
// optionally idles GAP_CYC cycles before the next grant.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles without a done tick (pulses timeout_tick). Without the macro
// WAIT is left only by tx_done_tick and timeout_tick stays 0.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int GAP_CYC = 0,
    parameter int TIMEOUT = 200000
) (
    input logic               clk,
    input logic               reset_n,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]      state;
    logic [IDW-1:0]  last_id;
    logic [15:0]     gap_cnt;

    logic [NREQ-1:0] grant_q;
    logic            tx_start_q;
    logic [DBIT-1:0] tx_din_q;
    logic            busy_q;
    logic [IDW-1:0]  cur_id_q;
    logic            timeout_q;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [DBIT-1:0] win_data;
    logic            done_ok;
    logic            wait_expired;

    // Search for the first requester after last_id, wrapping modulo NREQ,
    // so the most recently served requester is considered last.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int o = 1; o <= NREQ; o++) begin
            idx = int'(last_id) + o;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign win_data = bus.req_data[int'(win_id)*DBIT +: DBIT];

    // A done tick landing in the same cycle as our own tx_start cannot belong
    // to the character just launched, so it is discarded.
    assign done_ok = bus.tx_done_tick && !tx_start_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT + 1);

    logic [WCW-1:0] wait_cnt;

    assign wait_expired = (wait_cnt == WCW'(TIMEOUT - 1));

    // Count cycles spent in WAIT; held at zero in IDLE so every entry starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == S_IDLE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    // Arbitration FSM: grant in IDLE, wait for done (or timeout), then gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_id    <= IDW'(NREQ - 1);
            gap_cnt    <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
            busy_q     <= 1'b0;
            cur_id_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant_q    <= NREQ'(1) << win_id;
                        tx_start_q <= 1'b1;
                        tx_din_q   <= win_data;
                        cur_id_q   <= win_id;
                        last_id    <= win_id;
                        busy_q     <= 1'b1;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A real done in the expiry cycle wins; no timeout pulse then.
                    if (done_ok || wait_expired) begin
                        timeout_q <= !done_ok;
                        if (GAP_CYC == 0) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 16'(GAP_CYC - 1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_din       = tx_din_q;
    assign bus.busy         = busy_q;
    assign bus.cur_id       = cur_id_q;
    assign bus.timeout_tick = timeout_q;
    assign bus.state        = state;
endmodule
